dp_ctrl_sequencer: RTL and testbench
====================================

DP_CTRL_SEQUENCER -- requirements
Module: dp_ctrl_sequencer

Interface
REQ-001 Parameter CNT_W, default 4: width of the repeat-count field.
REQ-002 clock  input  1  single system clock; all state updates occur on its rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  sequencer can accept an operation.
REQ-006 req_op  input  2  operation code: 00 NOP, 01 LDA, 10 MOVAB, 11 ADDB.
REQ-007 req_imm  input  8  immediate byte for LDA.
REQ-008 req_count  input  CNT_W  ADDB repeat count.
REQ-009 ra_in, rb_in, rz_in  output  1 each  register load strobes for RA, RB, RZ.
REQ-010 ra_out, rb_out, rz_out  output  1 each  bus-drive selects for RA, RB, RZ.
REQ-011 imm_out  output  8  immediate value presented to RA's load input.
REQ-012 busy  output  1  operation in progress (state not IDLE).
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 Handshake: req_ready SHALL be 1 only in IDLE; an operation is accepted on a rising edge where req_valid && req_ready; req_op, req_imm and req_count are captured into internal registers at acceptance.
REQ-015 States SHALL be IDLE, LOAD_A, MOVE, ADD_Z, WB_B, FIN; all strobes, selects and done SHALL be decoded from registered state only (Moore), never from req_*.
REQ-016 NOP: IDLE -> FIN -> IDLE; no strobe or select asserted.
REQ-017 LDA: IDLE -> LOAD_A (ra_in=1, imm_out=captured imm) -> FIN -> IDLE.
REQ-018 MOVAB: IDLE -> MOVE (ra_out=1, rb_in=1) -> FIN -> IDLE.
REQ-019 ADDB: IDLE -> ADD_Z (rb_out=1, rz_in=1) -> WB_B (rz_out=1, rb_in=1) -> repeat or FIN; each pass computes RB <= RA + RB.
REQ-020 Repeat counter: loaded with captured count at acceptance, where count 0 is treated as 1; decremented in WB_B; WB_B -> ADD_Z while remaining > 1, else WB_B -> FIN.
REQ-021 FIN SHALL assert done=1 for exactly one cycle, then return to IDLE; req_ready rises in the cycle after done.
REQ-022 Bus rule: at most one of ra_out, rb_out, rz_out SHALL be 1 in any cycle; in IDLE and FIN all three SHALL be 0.
REQ-023 imm_out SHALL hold the last captured immediate outside LOAD_A (0 after reset).
REQ-024 req_valid while busy SHALL be ignored and SHALL NOT alter captured fields.

Reset
REQ-025 clear=0 SHALL immediately (asynchronously) force IDLE and drive all strobes, selects, done, busy=0, imm_out=0, counter=0, and req_ready=1 (inactive strobes from the first edge after release).
REQ-026 Reset during any state SHALL abandon the operation with no done pulse.

Configuration
REQ-027 Macro DP_CTRL_STATS_EN: when defined, add output op_count (16 bits), which increments on each done pulse, saturates at 0xFFFF and is reset to 0 by clear; when undefined, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-028 Package dp_ctrl_pkg SHALL hold the opcode enum (NOP/LDA/MOVAB/ADDB), the state enum, and the constant for the default CNT_W.
REQ-029 The repeat counter SHALL be a sub-module dp_ctrl_rep_counter (load, decrement, last flag).

Verification
REQ-030 LDA with imm=0x5A: ra_in=1 and imm_out=0x5A for exactly 1 cycle, done 2 cycles after acceptance, req_ready back 3 cycles after.
REQ-031 ADDB with count=3, RA=2, RB=1: three ADD_Z/WB_B pairs, RB sequence 3,5,7, done on cycle 7 after acceptance.
REQ-032 ADDB with count=0: behaves exactly as count=1, with a single pass and RB=RA+RB.
REQ-033 clear asserted mid-ADDB in WB_B: outputs 0 in the same cycle, no done, and a new MOVAB is accepted after release and completes normally.
REQ-034 Across all of the above cases, a bus-exclusivity check holds (no two of *_out high) and req_valid held high while busy causes no extra acceptance.
REQ-035 With DP_CTRL_STATS_EN defined, 5 back-to-back NOPs yield op_count=5.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared types and constants for the datapath control sequencer.
package dp_ctrl_pkg;

    localparam int unsigned DEFAULT_CNT_W = 4;
    localparam int unsigned IMM_W         = 8;
    localparam int unsigned OP_W          = 2;
    localparam int unsigned STATS_W       = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 2'b00,
        OP_LDA   = 2'b01,
        OP_MOVAB = 2'b10,
        OP_ADDB  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_MOVE   = 3'd2,
        ST_ADD_Z  = 3'd3,
        ST_WB_B   = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    // First working state entered when an operation is accepted.
    function automatic state_e entry_state(input op_e op);
        case (op)
            OP_LDA:   return ST_LOAD_A;
            OP_MOVAB: return ST_MOVE;
            OP_ADDB:  return ST_ADD_Z;
            default:  return ST_FIN;
        endcase
    endfunction

endpackage

// File: rtl/dp_ctrl_rep_counter.sv
// ADDB pass counter: loads the requested repeat count (0 treated as 1) and
// counts down once per write-back; last_c marks the final pass.
module dp_ctrl_rep_counter
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last_c
);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= (load_val == '0) ? CNT_W'(1) : load_val;
        end else if (dec && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign last_c = (remaining <= CNT_W'(1));

endmodule

// File: rtl/dp_ctrl_sequencer.sv
// Moore control sequencer for a three-register (RA/RB/RZ) bus datapath.
// Optional build macro DP_CTRL_STATS_EN adds a saturating op_count output.
module dp_ctrl_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [IMM_W-1:0] req_imm,
    input  logic [CNT_W-1:0] req_count,
    output logic             ra_in,
    output logic             rb_in,
    output logic             rz_in,
    output logic             ra_out,
    output logic             rb_out,
    output logic             rz_out,
    output logic [IMM_W-1:0] imm_out,
    output logic             busy,
    output logic             done
`ifdef DP_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0] op_count
`endif
);

    state_e state, state_next;
    logic   accept;
    logic   cnt_dec;
    logic   cnt_last;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus Moore decode of strobes/selects from the state register.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cnt_dec    = 1'b0;
        req_ready  = 1'b0;
        busy       = 1'b1;
        ra_in      = 1'b0;
        rb_in      = 1'b0;
        rz_in      = 1'b0;
        ra_out     = 1'b0;
        rb_out     = 1'b0;
        rz_out     = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = entry_state(op_e'(req_op));
                end
            end
            ST_LOAD_A: begin
                ra_in      = 1'b1;
                state_next = ST_FIN;
            end
            ST_MOVE: begin
                ra_out     = 1'b1;
                rb_in      = 1'b1;
                state_next = ST_FIN;
            end
            ST_ADD_Z: begin
                rb_out     = 1'b1;
                rz_in      = 1'b1;
                state_next = ST_WB_B;
            end
            ST_WB_B: begin
                rz_out     = 1'b1;
                rb_in      = 1'b1;
                cnt_dec    = 1'b1;
                state_next = cnt_last ? ST_FIN : ST_ADD_Z;
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Immediate is captured on every acceptance and held until the next one.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            imm_out <= '0;
        end else if (accept) begin
            imm_out <= req_imm;
        end
    end

    dp_ctrl_rep_counter #(
        .CNT_W (CNT_W)
    ) u_rep_counter (
        .clock    (clock),
        .clear    (clear),
        .load     (accept),
        .load_val (req_count),
        .dec      (cnt_dec),
        .last_c   (cnt_last)
    );

`ifdef DP_CTRL_STATS_EN
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_count <= '0;
        end else if ((state == ST_FIN) && (op_count != {STATS_W{1'b1}})) begin
            op_count <= op_count + STATS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dp_ctrl_sequencer.sv
// Scoreboard bench for dp_ctrl_sequencer with a small external RA/RB/RZ datapath.
module tb_dp_ctrl_sequencer;
    import dp_ctrl_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic             clock = 1'b0;
    logic             clear;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [7:0]       req_imm;
    logic [CNT_W-1:0] req_count;
    logic             ra_in, rb_in, rz_in, ra_out, rb_out, rz_out;
    logic [7:0]       imm_out;
    logic             busy, done;
`ifdef DP_CTRL_STATS_EN
    logic [15:0]      op_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [16:0] exp_q[$];
    logic [7:0]  rb_q[$];
    logic [7:0]  ra_m = 8'h00, rb_m = 8'h00, rz_m = 8'h00;
    logic [7:0]  bus;
    logic [7:0]  cur_imm = 8'h00;
    logic [7:0]  exp_ra = 8'h00, exp_rb = 8'h00;
    bit          prev_rb_in = 1'b0;

    dp_ctrl_sequencer #(.CNT_W(CNT_W)) dut (
        .clock     (clock),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_imm   (req_imm),
        .req_count (req_count),
        .ra_in     (ra_in),
        .rb_in     (rb_in),
        .rz_in     (rz_in),
        .ra_out    (ra_out),
        .rb_out    (rb_out),
        .rz_out    (rz_out),
        .imm_out   (imm_out),
        .busy      (busy),
        .done      (done)
`ifdef DP_CTRL_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clock = ~clock;

    // Register file driven by the sequencer's strobes; RZ latches RA + bus.
    assign bus = ra_out ? ra_m : rb_out ? rb_m : rz_out ? rz_m : 8'h00;
    always @(posedge clock) begin
        if (ra_in) ra_m <= imm_out;
        if (rb_in) rb_m <= bus;
        if (rz_in) rz_m <= ra_m + bus;
    end

    // Bus exclusivity and idle/fin quietness, every cycle.
    always @(negedge clock) begin
        n_checks++;
        if ((int'(ra_out) + int'(rb_out) + int'(rz_out)) > 1 ||
            ((req_ready || done) && (ra_out || rb_out || rz_out))) begin
            n_fails++;
            $display("FAIL bus_excl: got ra/rb/rz_out=%b%b%b ready=%b done=%b required at most one, none in idle/fin",
                     ra_out, rb_out, rz_out, req_ready, done);
        end
    end

    function automatic logic [16:0] w(input bit rai, input bit rbi, input bit rzi,
                                      input bit rao, input bit rbo, input bit rzo,
                                      input bit bsy, input bit dn, input bit rdy,
                                      input logic [7:0] im);
        return {rai, rbi, rzi, rao, rbo, rzo, bsy, dn, rdy, im};
    endfunction

    function automatic logic [16:0] observed();
        return {ra_in, rb_in, rz_in, ra_out, rb_out, rz_out, busy, done, req_ready, imm_out};
    endfunction

    // Expected per-cycle output words after acceptance, plus RB write-backs.
    task automatic push_trace(input op_e op, input logic [7:0] imm, input logic [CNT_W-1:0] cnt);
        int passes;
        cur_imm = imm;
        case (op)
            OP_LDA: begin
                exp_q.push_back(w(1,0,0,0,0,0,1,0,0,cur_imm));
                exp_ra = imm;
            end
            OP_MOVAB: begin
                exp_q.push_back(w(0,1,0,1,0,0,1,0,0,cur_imm));
                exp_rb = exp_ra;
                rb_q.push_back(exp_rb);
            end
            OP_ADDB: begin
                passes = (cnt == 0) ? 1 : int'(cnt);
                for (int p = 0; p < passes; p++) begin
                    exp_q.push_back(w(0,0,1,0,1,0,1,0,0,cur_imm));
                    exp_q.push_back(w(0,1,0,0,0,1,1,0,0,cur_imm));
                    exp_rb = exp_ra + exp_rb;
                    rb_q.push_back(exp_rb);
                end
            end
            default: ;
        endcase
        exp_q.push_back(w(0,0,0,0,0,0,1,1,0,cur_imm));
        exp_q.push_back(w(0,0,0,0,0,0,0,0,1,cur_imm));
    endtask

    // Issue one operation; if hold, keep req_valid high with junk fields while busy.
    task automatic do_op(input op_e op, input logic [7:0] imm, input logic [CNT_W-1:0] cnt, input bit hold);
        int n;
        logic [16:0] e;
        logic [7:0]  r;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL accept_ready: got req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_imm   = imm;
        req_count = cnt;
        push_trace(op, imm, cnt);
        n = exp_q.size();
        @(posedge clock);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (prev_rb_in) begin
                n_checks++;
                if (rb_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL rb_value: got unexpected rb write (rb=%h) required none", rb_m);
                end else begin
                    r = rb_q.pop_front();
                    if (rb_m !== r) begin
                        n_fails++;
                        $display("FAIL rb_value: got %h required %h", rb_m, r);
                    end
                end
            end
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_fails++;
                $display("FAIL op%0d_cycle%0d: got %b required %b (ri,ro,busy,done,ready,imm)",
                         int'(op), i + 1, observed(), e);
            end
            prev_rb_in = rb_in;
            if (hold && i < n - 1) begin
                req_op    = 2'($urandom_range(0, 3));
                req_imm   = 8'($urandom);
                req_count = CNT_W'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        clear     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_imm   = 8'h00;
        req_count = '0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (observed() !== w(0,0,0,0,0,0,0,0,1,8'h00)) begin
            n_fails++;
            $display("FAIL reset_state: got %b required %b", observed(), w(0,0,0,0,0,0,0,0,1,8'h00));
        end
        clear = 1'b1;
        @(negedge clock);
        n_checks++;
        if (observed() !== w(0,0,0,0,0,0,0,0,1,8'h00)) begin
            n_fails++;
            $display("FAIL post_release: got %b required %b", observed(), w(0,0,0,0,0,0,0,0,1,8'h00));
        end
    endtask

    task automatic test_lda();
        do_op(OP_LDA, 8'h5A, '0, 1'b1);
    endtask

    task automatic test_addb();
        do_op(OP_LDA, 8'h01, '0, 1'b0);
        do_op(OP_MOVAB, 8'h77, '0, 1'b1);
        do_op(OP_LDA, 8'h02, '0, 1'b0);
        do_op(OP_ADDB, 8'hC3, CNT_W'(3), 1'b1);
    endtask

    task automatic test_addb_zero();
        do_op(OP_ADDB, 8'h3C, '0, 1'b1);
    endtask

    task automatic test_nop();
        do_op(OP_NOP, 8'h11, CNT_W'(5), 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            do_op(op_e'(2'($urandom_range(0, 3))), 8'($urandom), CNT_W'($urandom_range(0, 3)), k[0]);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = OP_ADDB;
        req_imm   = 8'hE1;
        req_count = CNT_W'(3);
        @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (!(rb_out && rz_in)) begin
            n_fails++;
            $display("FAIL mid_add_z: got rb_out=%b rz_in=%b required 1 1", rb_out, rz_in);
        end
        @(negedge clock);
        n_checks++;
        if (!(rz_out && rb_in)) begin
            n_fails++;
            $display("FAIL mid_wb_b: got rz_out=%b rb_in=%b required 1 1", rz_out, rb_in);
        end
        #1 clear = 1'b0;
        req_valid = 1'b0;
        cur_imm   = 8'h00;
        #1;
        n_checks++;
        if (observed() !== w(0,0,0,0,0,0,0,0,1,8'h00)) begin
            n_fails++;
            $display("FAIL async_clear: got %b required %b", observed(), w(0,0,0,0,0,0,0,0,1,8'h00));
        end
        repeat (3) begin
            @(negedge clock);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fails++;
                $display("FAIL abort_no_done: got done=%b busy=%b required 0 0", done, busy);
            end
        end
        clear      = 1'b1;
        prev_rb_in = 1'b0;
        do_op(OP_MOVAB, 8'h33, '0, 1'b1);
    endtask

`ifdef DP_CTRL_STATS_EN
    task automatic test_stats();
        @(negedge clock);
        clear   = 1'b0;
        cur_imm = 8'h00;
        @(negedge clock);
        clear = 1'b1;
        for (int k = 0; k < 5; k++) do_op(OP_NOP, 8'(k), '0, 1'b0);
        n_checks++;
        if (op_count !== 16'd5) begin
            n_fails++;
            $display("FAIL op_count: got %0d required 5", op_count);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lda();
        test_addb();
        test_addb_zero();
        test_nop();
        test_back_to_back();
        test_reset_mid();
`ifdef DP_CTRL_STATS_EN
        test_stats();
`endif
        n_checks++;
        if (exp_q.size() != 0 || rb_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left required 0/0", exp_q.size(), rb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
